// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: turns a fixed-latency FIFO read port into a valid/ready stream.
// Optional statistics counters are enabled with `define FIFO_RD_STATS_EN.
module fifo_rd_stream #(
  parameter int DATA_W    = 128,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [DATA_W-1:0]                fifo_rddata,
  output logic                             fifo_rden,
  input  logic                             flush,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_W-1:0]                m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occ
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]                      stat_words,
  output logic [31:0]                      stat_stall,
  output logic [31:0]                      stat_starve
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SUM_W = $clog2(BUF_DEPTH + RD_LAT + 1);

  logic [DATA_W-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic [SUM_W-1:0]  credits_used;
  logic              clear;
  logic              capture;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits held by buffered words plus reads still travelling through the FIFO.
  always_comb begin
    credits_used = SUM_W'(count_q);
    for (int i = 0; i < RD_LAT; i++) begin
      credits_used = credits_used + SUM_W'(inflight_q[i]);
    end
  end

  assign clear     = ~reset | flush;
  assign fifo_rden = reset & ~flush & ~fifo_empty & (credits_used < SUM_W'(BUF_DEPTH));
  assign capture   = inflight_q[RD_LAT-1];
  assign pop       = m_valid & m_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    inflight_d    = '0;
    inflight_d[0] = fifo_rden;
    for (int i = 1; i < RD_LAT; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
    rd_ptr_d = pop     ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    case ({capture, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clear) begin
      inflight_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    inflight_q <= inflight_d;
    rd_ptr_q   <= rd_ptr_d;
    wr_ptr_q   <= wr_ptr_d;
    count_q    <= count_d;
  end

  // NOTE: the skid storage is reset (only a few entries) so m_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else if (capture && !flush) begin
      buf_q[wr_ptr_q] <= fifo_rddata;
    end
  end

  assign m_valid = (count_q != '0);
  assign m_data  = buf_q[rd_ptr_q];
  assign occ     = count_q;

`ifdef FIFO_RD_STATS_EN
  logic [31:0] words_q, stall_q, starve_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  // Flush wins over a same-cycle pop, so a flushed beat is not counted as a word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      words_q  <= '0;
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      words_q  <= sat_inc(words_q, pop & ~flush);
      stall_q  <= sat_inc(stall_q, m_valid & ~m_ready);
      starve_q <= sat_inc(starve_q, ~m_valid & m_ready & fifo_empty);
    end
  end

  assign stat_words  = words_q;
  assign stat_stall  = stall_q;
  assign stat_starve = starve_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed scoreboard bench: default instance (RD_LAT=1, BUF_DEPTH=3) and a
// RD_LAT=2, BUF_DEPTH=4 instance, each fed by a behavioural fixed-latency FIFO.
module tb_fifo_rd_stream;
  localparam int W = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  logic         f0_empty, f0_rden, flush0, m0_valid, m0_ready;
  logic [W-1:0] f0_rddata = '0, m0_data;
  logic [1:0]   occ0;
  logic         f1_empty, f1_rden, flush1, m1_valid, m1_ready;
  logic [W-1:0] f1_rddata = '0, f1_stage = '0, m1_data;
  logic [2:0]   occ1;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]  sw0, ss0, sv0, sw1, ss1, sv1;
`endif

  fifo_rd_stream dut0 (
    .clk(clk), .reset(reset), .fifo_empty(f0_empty), .fifo_rddata(f0_rddata),
    .fifo_rden(f0_rden), .flush(flush0), .m_valid(m0_valid), .m_ready(m0_ready),
    .m_data(m0_data), .occ(occ0)
`ifdef FIFO_RD_STATS_EN
    , .stat_words(sw0), .stat_stall(ss0), .stat_starve(sv0)
`endif
  );

  fifo_rd_stream #(.DATA_W(W), .RD_LAT(2), .BUF_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(f1_empty), .fifo_rddata(f1_rddata),
    .fifo_rden(f1_rden), .flush(flush1), .m_valid(m1_valid), .m_ready(m1_ready),
    .m_data(m1_data), .occ(occ1)
`ifdef FIFO_RD_STATS_EN
    , .stat_words(sw1), .stat_stall(ss1), .stat_starve(sv1)
`endif
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Behavioural FIFOs: word count updates non-blocking so fifo_empty never races the DUT edge.
  logic [W-1:0] fq0[$], fq1[$], exp0[$], exp1[$], log0[$];
  int fc0 = 0, fc1 = 0;
  assign f0_empty = (fc0 == 0);
  assign f1_empty = (fc1 == 0);

  always @(posedge clk) begin
    cyc++;
    if (f0_rden) begin
      f0_rddata <= fq0.pop_front();
      fc0 <= fc0 - 1;
    end
    if (f1_rden) begin
      f1_stage <= fq1.pop_front();
      fc1 <= fc1 - 1;
    end
    f1_rddata <= f1_stage;
  end

  task automatic push0(input logic [W-1:0] w);
    fq0.push_back(w); fc0++; exp0.push_back(w);
  endtask

  task automatic push1(input logic [W-1:0] w);
    fq1.push_back(w); fc1++; exp1.push_back(w);
  endtask

  // Output monitors sample on the falling edge, when outputs and drives are settled.
  int           rden0_cnt = 0, beats0 = 0, first_rden0 = -1, first_valid0 = -1;
  int           first_beat0 = -1, last_beat0 = -1;
  logic         hold0 = 1'b0;
  logic [W-1:0] hold_data0 = '0;
  always @(negedge clk) begin
    if (f0_rden) begin
      rden0_cnt++;
      if (first_rden0 < 0) first_rden0 = cyc;
    end
    if (m0_valid && first_valid0 < 0) first_valid0 = cyc;
    if (hold0) begin
      check("hold_valid0", W'(m0_valid), 1);
      check("hold_data0", m0_data, hold_data0);
    end
    if (m0_valid && m0_ready && !flush0) begin
      check("beat0_pending", W'(exp0.size() > 0), 1);
      if (exp0.size() > 0) check("beat0_data", m0_data, exp0.pop_front());
      log0.push_back(m0_data);
      beats0++;
      if (first_beat0 < 0) first_beat0 = cyc;
      last_beat0 = cyc;
    end
    hold0      = m0_valid && !m0_ready && !flush0 && reset;
    hold_data0 = m0_data;
  end

  int beats1 = 0, first_beat1 = -1, last_beat1 = -1;
  always @(negedge clk) begin
    if (m1_valid && m1_ready) begin
      check("beat1_pending", W'(exp1.size() > 0), 1);
      if (exp1.size() > 0) check("beat1_data", m1_data, exp1.pop_front());
      beats1++;
      if (first_beat1 < 0) first_beat1 = cyc;
      last_beat1 = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic drain0(input string tag, input int max);
    int n = 0;
    while (exp0.size() != 0 && n < max) begin settle(); n++; end
    check(tag, W'(exp0.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r, b, nd;
    flush0 = 1'b0; flush1 = 1'b0; m0_ready = 1'b0; m1_ready = 1'b1;

    // 1: reset held with a non-empty FIFO
    for (int i = 0; i < 16; i++) push0(W'(i));
    repeat (3) begin
      settle();
      check("rst_rden", W'(f0_rden), 0);
      check("rst_valid", W'(m0_valid), 0);
      check("rst_occ", W'(occ0), 0);
      check("rst_data", m0_data, 0);
    end

    // 2: preloaded FIFO, consumer always ready
    step();
    m0_ready = 1'b1;
    reset    = 1'b1;
    drain0("drain_t2", 40);
    check("t2_latency", W'(first_valid0 - first_rden0), 2);
    check("t2_beats", W'(beats0), 16);
    check("t2_gapless", W'(last_beat0 - first_beat0), 15);
    repeat (3) settle();
    check("t2_idle_valid", W'(m0_valid), 0);
    check("t2_idle_occ", W'(occ0), 0);

    // 3: backpressure
    step();
    m0_ready = 1'b0;
    r = rden0_cnt; b = beats0;
    for (int i = 0; i < 16; i++) push0(W'(i));
    repeat (10) settle();
    check("t3_rden_pulses", W'(rden0_cnt - r), 3);
    check("t3_rden_low", W'(f0_rden), 0);
    check("t3_occ", W'(occ0), 3);
    check("t3_data", m0_data, 0);
    check("t3_valid", W'(m0_valid), 1);
    step();
    m0_ready = 1'b1;
    drain0("drain_t3", 40);
    check("t3_beats", W'(beats0 - b), 16);

    // 4: single word into an empty FIFO
    repeat (3) begin
      settle();
      check("t4_empty_rden", W'(f0_rden), 0);
    end
    step();
    r = rden0_cnt; b = beats0;
    push0(W'(8'hA5));
    repeat (6) settle();
    check("t4_rden_pulses", W'(rden0_cnt - r), 1);
    check("t4_beats", W'(beats0 - b), 1);
    check("t4_data", log0[log0.size()-1], W'(8'hA5));
    check("t4_idle_rden", W'(f0_rden), 0);

    // 5: flush with two buffered words and one read in flight
    step();
    m0_ready = 1'b0;
    push0(W'(4)); push0(W'(5));
    repeat (5) settle();
    check("t5_occ_pre", W'(occ0), 2);
    step();
    push0(W'(6));
    step();
    check("t5_occ_flight", W'(occ0), 2);
    flush0 = 1'b1;
    #1;
    check("t5_flush_rden", W'(f0_rden), 0);
    nd = exp0.size() - fc0;
    for (int i = 0; i < nd; i++) void'(exp0.pop_front());
    step();
    flush0 = 1'b0;
    check("t5_valid_after", W'(m0_valid), 0);
    check("t5_occ_after", W'(occ0), 0);
    b = beats0;
    push0(W'(7)); push0(W'(8));
    m0_ready = 1'b1;
    drain0("drain_t5", 20);
    check("t5_beats", W'(beats0 - b), 2);
    if (beats0 > b) check("t5_next_word", log0[b], W'(7));

    // 6: RD_LAT=2, BUF_DEPTH=4 instance
    step();
    for (int i = 0; i < 32; i++) push1(W'(32'h100 + i));
    begin
      int n = 0;
      while (exp1.size() != 0 && n < 80) begin settle(); n++; end
    end
    check("drain_t6", W'(exp1.size()), 0);
    check("t6_beats", W'(beats1), 32);
    check("t6_gapless", W'(last_beat1 - first_beat1), 31);
`ifdef FIFO_RD_STATS_EN
    check("t6_stat_words", W'(sw1), 32);
    check("t6_stat_stall", W'(ss1), 0);
    check("stat_words0", W'(sw0), W'(beats0));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drain stage that sits directly downstream of the 128-bit sync FIFO. It converts the FIFO's rden/empty/rddata port (fixed read latency) into a valid/ready stream for the consumer. A small credit-tracked skid buffer absorbs in-flight reads, so the stream sustains 1 word/cycle with no data loss under backpressure.

Parameters:
DATA_W, 128, width of FIFO read data and stream data
RD_LAT, 1, FIFO read latency in cycles from fifo_rden edge to valid fifo_rddata (legal 1..2)
BUF_DEPTH, 3, skid buffer entries; legal min RD_LAT+1; full throughput requires >= RD_LAT+2

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low reset
fifo_empty  in  1  FIFO o_empty
fifo_rddata  in  DATA_W  FIFO o_rddata
fifo_rden  out  1  FIFO i_rden
flush  in  1  synchronous discard of buffered and in-flight data
m_valid  out  1  stream data valid
m_ready  in  1  consumer ready
m_data  out  DATA_W  stream data
occ  out  $clog2(BUF_DEPTH+1)  current skid buffer occupancy

Behaviour:
- Reset: clk and reset ports keep the codebase names; reset is one clock domain, synchronous and active-low. While reset=0, at each posedge: count, rd_ptr, wr_ptr and inflight shift register clear to 0. fifo_rden is combinationally forced to 0 while reset=0. After reset: m_valid=0, occ=0, m_data=0.
- State: circular buffer of BUF_DEPTH×DATA_W; rd_ptr, wr_ptr wrap at BUF_DEPTH-1 -> 0; count; inflight[RD_LAT-1:0] shift register.
- Issue rule (combinational): fifo_rden = reset & !flush & !fifo_empty & (count + popcount(inflight) < BUF_DEPTH). Same-cycle pop earns no credit, so there is no m_ready -> fifo_rden path.
- inflight shifts each cycle; inflight[0] <= fifo_rden.
- Capture: when inflight[RD_LAT-1]=1, fifo_rddata is written at wr_ptr and wr_ptr advances. The credit rule guarantees no overflow; no overflow check is required.
- Pop: pop = m_valid & m_ready advances rd_ptr.
- Count: capture and pop in the same cycle leave count unchanged.
- Outputs: m_valid = (count != 0); m_data = buf[rd_ptr]; occ = count. All three are driven from registers only.
- Stream rule: once m_valid=1, m_valid and m_data hold stable until accepted. Order is strictly the FIFO order.
- Latency: with an idle buffer and RD_LAT=1, fifo_rden in cycle N gives m_valid in cycle N+2.
- Flush: at a posedge with flush=1, count, pointers and inflight clear, so words returning later are dropped. fifo_rden=0 during the flush cycle. m_valid=0 from the next cycle. Words still in the FIFO are untouched. Flush and pop in the same cycle: flush wins.
- Reset low mid-operation: same effect as flush.
- fifo_empty=1: no issue. Buffered words still drain.

Optional Feature:
FIFO_RD_STATS_EN:
- Defined: adds outputs stat_words[31:0], stat_stall[31:0], stat_starve[31:0].
  - stat_words counts pops.
  - stat_stall counts cycles with m_valid & !m_ready.
  - stat_starve counts cycles with !m_valid & m_ready & fifo_empty.
  - Counters saturate at 0xFFFFFFFF, clear on reset only (not on flush), and are registered.
- Undefined: the ports and counters do not exist and datapath behaviour is identical.

Test Plan:
1. Reset=0 for 3 cycles with fifo_empty=0 -> fifo_rden=0 every cycle, m_valid=0, occ=0.
2. FIFO preloaded with words 0..15, m_ready=1 held, default params -> first m_valid 2 cycles after first fifo_rden; 16 gapless beats in order 0..15; then m_valid=0.
3. m_ready=0 with 16 words available -> exactly 3 fifo_rden pulses, then fifo_rden stays 0; occ=3, m_data=0 stable. Raise m_ready -> beats 0..15 in order, no loss.
4. Single word 0xA5 written into an empty FIFO -> exactly one fifo_rden and one beat with m_data=0xA5; fifo_rden=0 while fifo_empty=1.
5. occ=2 (words 4,5) plus 1 in flight (word 6), assert flush one cycle -> m_valid=0 next cycle; word 6 is dropped; after flush the next beat is word 7.
6. RD_LAT=2, BUF_DEPTH=4, 32 words, m_ready=1 -> gapless 32 beats in order. With FIFO_RD_STATS_EN defined: stat_words=32, stat_stall=0.
